stepper_move_controller: RTL and testbench

Move sequencer for the 28BYJ-48 unipolar stepper. It accepts one move command at a time: step count, direction, drive mode and step period. It generates the coil pattern on A/B/C/D directly, at a programmable step rate, and tracks an absolute position counter. It sits between the board-level command source (buttons/switches or a UART decoder) and the ULN2003 driver pins. It replaces the free-running step generator with a counted, handshaked, abortable move.

---
 rtl/stepper_move_controller_pkg.sv | 46 ++++
 rtl/stepper_move_controller_tick_timer.sv | 27 ++
 rtl/stepper_move_controller.sv | 147 ++++++++++++++
 tb/tb_stepper_move_controller.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/stepper_move_controller_pkg.sv
// Shared stepper definitions: FSM states, drive-mode encodings and the 8-entry
// unipolar phase table, reused by the future bipolar/microstep blocks.
package stepper_move_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] MODE_WAVE = 2'b00;
  localparam logic [1:0] MODE_FULL = 2'b01;
  localparam logic [1:0] MODE_HALF = 2'b10;

  function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
    logic [3:0] pat;
    case (idx)
      3'd0: pat = 4'b1000;
      3'd1: pat = 4'b1100;
      3'd2: pat = 4'b0100;
      3'd3: pat = 4'b0110;
      3'd4: pat = 4'b0010;
      3'd5: pat = 4'b0011;
      3'd6: pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
    return pat;
  endfunction

  // Wave lives on even indices, full on odd; a parity mismatch costs one
  // single-index alignment step before the mode's normal stride of 2.
  function automatic logic [2:0] phase_advance(input logic [2:0] phase,
                                               input logic [1:0] mode,
                                               input logic       dir);
    logic [2:0] delta;
    case (mode)
      MODE_HALF:            delta = 3'd1;
      MODE_FULL:            delta = phase[0] ? 3'd2 : 3'd1;
      MODE_WAVE, 2'b11:     delta = phase[0] ? 3'd1 : 3'd2;
      default:              delta = 3'd1;
    endcase
    return dir ? phase + delta : phase - delta;
  endfunction

endpackage

// File: rtl/stepper_move_controller_tick_timer.sv
// Loadable down-counter; tick is high while the count sits at zero.
module stepper_move_controller_tick_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         tick
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/stepper_move_controller.sv
// Counted, handshaked, abortable move sequencer for the 28BYJ-48 stepper
// driving the ULN2003 coil pins directly.
module stepper_move_controller
  import stepper_move_controller_pkg::*;
#(
  parameter int STEPS_W    = 16,
  parameter int PERIOD_W   = 20,
  parameter int POS_W      = 24,
  parameter int MIN_PERIOD = 100000,
  parameter int SETTLE_CYC = 50000,
  parameter bit HOLD_EN    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [STEPS_W-1:0]  cmd_steps,
  input  logic                cmd_dir,
  input  logic [1:0]          cmd_mode,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic [3:0]          salidaMotor,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [POS_W-1:0]    position,
  output logic                ledDireccion
);

  localparam int SETTLE_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);

  state_t              state;
  logic [2:0]          phase;
  logic [2:0]          phase_nxt;
  logic [STEPS_W-1:0]  remaining;
  logic                dir_q;
  logic [1:0]          mode_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] period_eff;
  logic [PERIOD_W-1:0] step_reload;
  logic                step_tick;
  logic                settle_tick;
  logic                accept;
  logic                step_now;
  logic                enter_settle;

  assign period_eff   = (cmd_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : cmd_period;
  assign step_reload  = accept ? period_eff - PERIOD_W'(1) : period_q - PERIOD_W'(1);
  assign accept       = cmd_valid && cmd_ready && (state == ST_IDLE);
  // Abort beats a coincident step tick, so the step is simply never taken.
  assign step_now     = (state == ST_RUN) && step_tick && !abort;
  assign enter_settle = (state == ST_RUN) && (abort || (step_tick && remaining == STEPS_W'(1)));
  assign phase_nxt    = phase_advance(phase, mode_q, dir_q);

  stepper_move_controller_tick_timer #(.W(PERIOD_W)) u_step_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (accept || step_now),
    .value (step_reload),
    .en    (state == ST_RUN),
    .tick  (step_tick)
  );

  stepper_move_controller_tick_timer #(.W(SETTLE_W)) u_settle_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (enter_settle),
    .value (SETTLE_W'(SETTLE_CYC - 1)),
    .en    (state == ST_SETTLE),
    .tick  (settle_tick)
  );

  // The coil register is written with the pattern of the phase being entered,
  // so each step's coil change lands on the same edge as the step itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      salidaMotor  <= 4'b0000;
      phase        <= 3'd0;
      position     <= '0;
      remaining    <= '0;
      dir_q        <= 1'b0;
      mode_q       <= MODE_WAVE;
      period_q     <= '0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      ledDireccion <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dir_q        <= cmd_dir;
            mode_q       <= cmd_mode;
            period_q     <= period_eff;
            remaining    <= cmd_steps;
            ledDireccion <= cmd_dir;
            aborted      <= 1'b0;
            cmd_ready    <= 1'b0;
            if (cmd_steps != '0) begin
              state       <= ST_RUN;
              busy        <= 1'b1;
              salidaMotor <= phase_pattern(phase);
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            aborted <= 1'b1;
          end else if (step_tick) begin
            phase       <= phase_nxt;
            salidaMotor <= phase_pattern(phase_nxt);
            position    <= dir_q ? position + POS_W'(1) : position - POS_W'(1);
            remaining   <= remaining - STEPS_W'(1);
          end
          if (enter_settle) begin
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            aborted <= 1'b1;
          end
          if (settle_tick) begin
            state       <= ST_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            salidaMotor <= HOLD_EN ? phase_pattern(phase) : 4'b0000;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_move_controller.sv
// Directed bench for stepper_move_controller with shortened period/settle
// parameters; move vectors come from a table, corner cases are hand-written.
module tb_stepper_move_controller;

  localparam int MINP   = 20;
  localparam int SETTLE = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_steps = '0;
  logic        cmd_dir = 1'b0;
  logic [1:0]  cmd_mode = 2'b00;
  logic [19:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic [3:0]  salidaMotor;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [23:0] position;
  logic        ledDireccion;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic [15:0] steps;
    logic        dir;
    logic [1:0]  mode;
    logic [19:0] period;
    int          eff;
    logic [3:0]  startPat;
    logic [31:0] pats;
    logic [23:0] expPos;
  } vec_t;

  vec_t vecs[7];

  stepper_move_controller #(
    .STEPS_W(16), .PERIOD_W(20), .POS_W(24),
    .MIN_PERIOD(MINP), .SETTLE_CYC(SETTLE), .HOLD_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_mode(cmd_mode),
    .cmd_period(cmd_period), .abort(abort), .salidaMotor(salidaMotor),
    .busy(busy), .done(done), .aborted(aborted), .position(position),
    .ledDireccion(ledDireccion)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checkCount++;
    if (act !== expv) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Offers one command for a single edge; returns at accept edge + 1.
  task automatic applyStimulus(input logic [15:0] steps, input logic dir,
                               input logic [1:0] mode, input logic [19:0] period);
    checkOutput("ready_before_accept", {31'b0, cmd_ready}, 32'd1);
    cmd_steps  = steps;
    cmd_dir    = dir;
    cmd_mode   = mode;
    cmd_period = period;
    cmd_valid  = 1'b1;
    tick(1);
    cmd_valid  = 1'b0;
  endtask

  task automatic checkIdleReset(input string tag);
    checkOutput({tag, "_coils"}, {28'b0, salidaMotor}, 32'h0);
    checkOutput({tag, "_pos"}, {8'b0, position}, 32'h0);
    checkOutput({tag, "_ready"}, {31'b0, cmd_ready}, 32'd1);
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'b0, done}, 32'd0);
    checkOutput({tag, "_aborted"}, {31'b0, aborted}, 32'd0);
    checkOutput({tag, "_led"}, {31'b0, ledDireccion}, 32'd0);
  endtask

  initial begin
    logic [3:0] prev;

    // Nibble k of pats is the coil pattern after step k+1.
    vecs[0] = '{16'd4, 1'b1, 2'b00, 20'd20, 20, 4'b1000, 32'h0000_8124, 24'd4};
    vecs[1] = '{16'd8, 1'b0, 2'b10, 20'd20, 20, 4'b1000, 32'h8C46_2319, -24'sd4};
    vecs[2] = '{16'd2, 1'b1, 2'b10, 20'd20, 20, 4'b1000, 32'h0000_004C, -24'sd2};
    vecs[3] = '{16'd3, 1'b1, 2'b01, 20'd25, 25, 4'b0100, 32'h0000_0936, 24'd1};
    vecs[4] = '{16'd1, 1'b0, 2'b00, 20'd10, 20, 4'b1001, 32'h0000_0001, 24'd0};
    vecs[5] = '{16'd2, 1'b1, 2'b11, 20'd20, 20, 4'b0001, 32'h0000_0048, 24'd2};
    vecs[6] = '{16'd0, 1'b0, 2'b00, 20'd30, 30, 4'b0100, 32'h0000_0000, 24'd2};

    #3 rst = 1'b1;
    #4 checkIdleReset("reset");
    @(posedge clk); #1 rst = 1'b0;
    tick(1);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].steps, vecs[i].dir, vecs[i].mode, vecs[i].period);
      if (vecs[i].steps == 16'd0) begin
        checkOutput($sformatf("v%0d_zero_done", i), {31'b0, done}, 32'd1);
        checkOutput($sformatf("v%0d_zero_coils", i), {28'b0, salidaMotor}, {28'b0, vecs[i].startPat});
        checkOutput($sformatf("v%0d_zero_busy", i), {31'b0, busy}, 32'd0);
        checkOutput($sformatf("v%0d_zero_ready", i), {31'b0, cmd_ready}, 32'd0);
      end else begin
        checkOutput($sformatf("v%0d_busy", i), {31'b0, busy}, 32'd1);
        checkOutput($sformatf("v%0d_start", i), {28'b0, salidaMotor}, {28'b0, vecs[i].startPat});
        prev = vecs[i].startPat;
        for (int k = 0; k < int'(vecs[i].steps); k++) begin
          tick(vecs[i].eff - 1);
          checkOutput($sformatf("v%0d_hold%0d", i, k), {28'b0, salidaMotor}, {28'b0, prev});
          tick(1);
          prev = vecs[i].pats[4*k +: 4];
          checkOutput($sformatf("v%0d_step%0d", i, k), {28'b0, salidaMotor}, {28'b0, prev});
        end
        tick(SETTLE - 1);
        checkOutput($sformatf("v%0d_settle_done", i), {31'b0, done}, 32'd0);
        checkOutput($sformatf("v%0d_settle_busy", i), {31'b0, busy}, 32'd1);
        tick(1);
        checkOutput($sformatf("v%0d_done", i), {31'b0, done}, 32'd1);
        checkOutput($sformatf("v%0d_done_busy", i), {31'b0, busy}, 32'd0);
        checkOutput($sformatf("v%0d_done_ready", i), {31'b0, cmd_ready}, 32'd0);
        checkOutput($sformatf("v%0d_hold_coils", i), {28'b0, salidaMotor}, {28'b0, prev});
      end
      checkOutput($sformatf("v%0d_pos", i), {8'b0, position}, {8'b0, vecs[i].expPos});
      checkOutput($sformatf("v%0d_led", i), {31'b0, ledDireccion}, {31'b0, vecs[i].dir});
      checkOutput($sformatf("v%0d_aborted", i), {31'b0, aborted}, 32'd0);
      tick(1);
      checkOutput($sformatf("v%0d_after_done", i), {31'b0, done}, 32'd0);
      checkOutput($sformatf("v%0d_ready_back", i), {31'b0, cmd_ready}, 32'd1);
    end

    // Abort on the step-3 tick of a 10-step wave move from phase 2, position 2.
    applyStimulus(16'd10, 1'b1, 2'b00, 20'd20);
    tick(20);
    checkOutput("abort_step1", {28'b0, salidaMotor}, 32'h2);
    tick(10);
    cmd_steps = 16'd1; cmd_dir = 1'b0; cmd_valid = 1'b1;
    tick(1);
    checkOutput("abort_ready_busy", {31'b0, cmd_ready}, 32'd0);
    tick(9);
    checkOutput("abort_step2", {28'b0, salidaMotor}, 32'h1);
    tick(10);
    cmd_valid = 1'b0;
    tick(9);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    checkOutput("abort_no_step3", {28'b0, salidaMotor}, 32'h1);
    checkOutput("abort_pos", {8'b0, position}, 32'd4);
    checkOutput("abort_flag", {31'b0, aborted}, 32'd1);
    checkOutput("abort_busy", {31'b0, busy}, 32'd1);
    tick(SETTLE - 1);
    checkOutput("abort_pre_done", {31'b0, done}, 32'd0);
    tick(1);
    checkOutput("abort_done", {31'b0, done}, 32'd1);
    checkOutput("abort_flag_done", {31'b0, aborted}, 32'd1);
    tick(1);
    checkOutput("abort_done_once", {31'b0, done}, 32'd0);
    checkOutput("abort_led", {31'b0, ledDireccion}, 32'd1);
    checkOutput("abort_pos_final", {8'b0, position}, 32'd4);
    tick(40);
    checkOutput("abort_no_late_step", {28'b0, salidaMotor}, 32'h1);

    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkIdleReset("reset2");
    tick(1);

    // Five steps of a 6-step move, then an asynchronous reset mid-cycle.
    applyStimulus(16'd6, 1'b1, 2'b00, 20'd20);
    tick(100);
    checkOutput("mid_pos", {8'b0, position}, 32'd5);
    checkOutput("mid_coils", {28'b0, salidaMotor}, 32'h4);
    #2 rst = 1'b1;
    #1 checkIdleReset("async_reset");
    @(posedge clk); #1 rst = 1'b0;
    tick(1);

    applyStimulus(16'd0, 1'b1, 2'b01, 20'd50);
    checkOutput("zero_done", {31'b0, done}, 32'd1);
    checkOutput("zero_coils", {28'b0, salidaMotor}, 32'h0);
    checkOutput("zero_pos", {8'b0, position}, 32'd0);
    checkOutput("zero_led", {31'b0, ledDireccion}, 32'd1);
    tick(1);
    checkOutput("zero_done_end", {31'b0, done}, 32'd0);
    checkOutput("zero_ready", {31'b0, cmd_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
